// File: rtl/exception_sequencer.sv
// exception_sequencer: multicycle-CPU exception controller.
// Arbitrates raw exception flags (opcode > overflow > divzero), reads the
// handler byte from the vector address (253/254/255), then saves EPC and
// redirects the PC in a single commit cycle. The main control FSM holds
// while busy is high.
// Optional build macro EXC_CAUSE_REG_EN: when defined, cause is a register
// loaded with the winning code; when undefined, cause is tied to 2'b00.
module exception_sequencer #(
    parameter int MEM_LATENCY   = 2,
    parameter int EPC_OFFSET    = 4,
    parameter int ADDR_OPCODE   = 253,
    parameter int ADDR_OVERFLOW = 254,
    parameter int ADDR_DIVZERO  = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_atual,
    input  logic [7:0]  mem_data_in,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_load,
    output logic [31:0] pc_data,
    output logic [1:0]  cause
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [3:0]  WAIT_LOAD  = 4'(MEM_LATENCY - 1);
    localparam logic [31:0] EPC_OFF_W  = 32'(EPC_OFFSET);
    localparam logic [31:0] VEC_OPCODE = 32'(ADDR_OPCODE);
    localparam logic [31:0] VEC_OVF    = 32'(ADDR_OVERFLOW);
    localparam logic [31:0] VEC_DIVZ   = 32'(ADDR_DIVZERO);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [3:0]  wait_cnt;
    logic        any_flag;
    logic        start_seq;
    logic        wait_done;
    logic [31:0] win_addr;

    assign any_flag  = exc_opcode | exc_overflow | exc_divzero;
    assign start_seq = (state == ST_IDLE) && any_flag;
    assign wait_done = (state == ST_WAIT) && (wait_cnt == 4'd0);

    // Fixed-priority selection of the vector address: opcode > overflow > divzero.
    always_comb begin
        win_addr = 32'd0;
        if (exc_opcode) begin
            win_addr = VEC_OPCODE;
        end else if (exc_overflow) begin
            win_addr = VEC_OVF;
        end else if (exc_divzero) begin
            win_addr = VEC_DIVZ;
        end else begin
            win_addr = 32'd0;
        end
    end

    // Next-state logic; flags are only looked at while idle, so anything
    // raised during a sequence is dropped rather than queued.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = any_flag ? ST_REQ : ST_IDLE;
            ST_REQ:    state_next = ST_WAIT;
            ST_WAIT:   state_next = (wait_cnt == 4'd0) ? ST_COMMIT : ST_WAIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and registered control outputs, decoded from the next state
    // so every strobe lines up exactly with the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            epc_write <= 1'b0;
            pc_load   <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != ST_IDLE);
            mem_read  <= (state_next == ST_REQ) || (state_next == ST_WAIT);
            epc_write <= (state_next == ST_COMMIT);
            pc_load   <= (state_next == ST_COMMIT);
        end
    end

    // Datapath: latch vector address and EPC at sequence start, count the
    // memory latency, and capture the handler byte when the count expires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr <= 32'd0;
            epc_data <= 32'd0;
            pc_data  <= 32'd0;
            wait_cnt <= 4'd0;
        end else begin
            if (start_seq) begin
                mem_addr <= win_addr;
                epc_data <= pc_atual - EPC_OFF_W;
            end else begin
                mem_addr <= mem_addr;
                epc_data <= epc_data;
            end

            if (state == ST_REQ) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else begin
                wait_cnt <= wait_cnt;
            end

            if (wait_done) begin
                pc_data <= {24'd0, mem_data_in};
            end else begin
                pc_data <= pc_data;
            end
        end
    end

`ifdef EXC_CAUSE_REG_EN
    logic [1:0] win_code;

    // Encoded cause of the winning flag (01 opcode, 10 overflow, 11 divzero).
    always_comb begin
        win_code = 2'b00;
        if (exc_opcode) begin
            win_code = 2'b01;
        end else if (exc_overflow) begin
            win_code = 2'b10;
        end else if (exc_divzero) begin
            win_code = 2'b11;
        end else begin
            win_code = 2'b00;
        end
    end

    // Cause register: loaded on sequence start, held until the next exception.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cause <= 2'b00;
        end else if (start_seq) begin
            cause <= win_code;
        end else begin
            cause <= cause;
        end
    end
`else
    assign cause = 2'b00;
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer: two instances (latency 2 and 1)
// share the flag/PC stimulus; a transaction-level model predicts each output.
module tb_exception_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_divzero = 1'b0;
    logic [31:0] pc_atual = 32'd0;
    logic [7:0]  mem_data [2];

    logic [1:0]  busy_v, read_v, epcw_v, pcl_v;
    logic [31:0] addr_v [2];
    logic [31:0] epcd_v [2];
    logic [31:0] pcd_v  [2];
    logic [1:0]  cause_v [2];

    int lat [2] = '{2, 1};
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    // model state per instance
    bit          have [2];
    int          s_edge [2];
    int          win_idx [2];
    logic [31:0] exp_addr [2];
    logic [31:0] exp_epc [2];
    logic [31:0] exp_pcd [2];
    logic [1:0]  exp_cause [2];
    logic [7:0]  mem_tbl [3];
    int          rd_cnt [2];

    always #5 clock = ~clock;

    exception_sequencer #(.MEM_LATENCY(2)) dut0 (
        .clock(clock), .reset(reset),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .pc_atual(pc_atual), .mem_data_in(mem_data[0]),
        .busy(busy_v[0]), .mem_addr(addr_v[0]), .mem_read(read_v[0]),
        .epc_write(epcw_v[0]), .epc_data(epcd_v[0]), .pc_load(pcl_v[0]),
        .pc_data(pcd_v[0]), .cause(cause_v[0])
    );

    exception_sequencer #(.MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .pc_atual(pc_atual), .mem_data_in(mem_data[1]),
        .busy(busy_v[1]), .mem_addr(addr_v[1]), .mem_read(read_v[1]),
        .epc_write(epcw_v[1]), .epc_data(epcd_v[1]), .pc_load(pcl_v[1]),
        .pc_data(pcd_v[1]), .cause(cause_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model reaction to one rising edge, using the inputs present before it.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit idle_before;
            idle_before = !(have[i] && ((cyc - 1 - s_edge[i]) <= lat[i] + 1));
            if (idle_before && (exc_opcode || exc_overflow || exc_divzero)) begin
                have[i]   = 1'b1;
                s_edge[i] = cyc;
                win_idx[i] = exc_opcode ? 0 : (exc_overflow ? 1 : 2);
                exp_addr[i]  = 32'd253 + 32'(win_idx[i]);
                exp_cause[i] = 2'(win_idx[i] + 1);
                exp_epc[i]   = pc_atual - 32'd4;
            end
            if (have[i] && (cyc - s_edge[i]) == lat[i] + 1)
                exp_pcd[i] = {24'd0, mem_tbl[win_idx[i]]};
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int  d;
            bit  act;
            logic [1:0] ec;
            d   = cyc - s_edge[i];
            act = have[i] && (d <= lat[i] + 1);
            check($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(act));
            check($sformatf("mem_read%0d", i), 32'(read_v[i]), 32'(act && d <= lat[i]));
            check($sformatf("pc_load%0d", i), 32'(pcl_v[i]), 32'(act && d == lat[i] + 1));
            check($sformatf("epc_write%0d", i), 32'(epcw_v[i]), 32'(act && d == lat[i] + 1));
            check($sformatf("mem_addr%0d", i), addr_v[i], exp_addr[i]);
            check($sformatf("pc_data%0d", i), pcd_v[i], exp_pcd[i]);
            if (act && d == lat[i] + 1)
                check($sformatf("epc_data%0d", i), epcd_v[i], exp_epc[i]);
`ifdef EXC_CAUSE_REG_EN
            ec = exp_cause[i];
`else
            ec = 2'b00;
`endif
            check($sformatf("cause%0d", i), 32'(cause_v[i]), 32'(ec));
        end
    endtask

    // Memory: byte at the requested address becomes valid L cycles after mem_read rises.
    task automatic drive_mem();
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            rd_cnt[i] = read_v[i] ? rd_cnt[i] + 1 : 0;
            b = (addr_v[i] >= 32'd253 && addr_v[i] <= 32'd255) ? mem_tbl[addr_v[i] - 32'd253] : 8'h00;
            mem_data[i] = (rd_cnt[i] > lat[i]) ? b : ~b;
        end
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        compare_all();
        drive_mem();
    endtask

    task automatic drive(input logic op, input logic ov, input logic dz, input logic [31:0] pc);
        exc_opcode = op; exc_overflow = ov; exc_divzero = dz; pc_atual = pc;
        step();
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, $urandom);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            have[i] = 1'b0; exp_addr[i] = 32'd0; exp_pcd[i] = 32'd0;
            exp_cause[i] = 2'b00; exp_epc[i] = 32'd0; rd_cnt[i] = 0;
            mem_data[i] = 8'h00;
            check($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_read%0d", i), 32'(read_v[i]), 32'd0);
            check($sformatf("rst_pcload%0d", i), 32'(pcl_v[i]), 32'd0);
            check($sformatf("rst_epcw%0d", i), 32'(epcw_v[i]), 32'd0);
            check($sformatf("rst_addr%0d", i), addr_v[i], 32'd0);
            check($sformatf("rst_epcd%0d", i), epcd_v[i], 32'd0);
            check($sformatf("rst_pcd%0d", i), pcd_v[i], 32'd0);
            check($sformatf("rst_cause%0d", i), 32'(cause_v[i]), 32'd0);
        end
        @(posedge clock);
        cyc++;
        #1;
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        mem_data[0] = 8'h00;
        mem_data[1] = 8'h00;
        mem_tbl[0] = 8'h80; mem_tbl[1] = 8'h3C; mem_tbl[2] = 8'hFF;
        do_reset();
        idle_steps(2);

        // opcode pulse, pc 0x40, handler byte 0x80
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0040);
        idle_steps(6);

        // overflow and divzero on the same edge: overflow wins
        drive(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        idle_steps(6);

        // divzero at pc 0: EPC wraps to 0xFFFFFFFC
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0000);
        idle_steps(6);

        // second opcode pulse while the first sequence is still waiting
        drive(1'b1, 1'b0, 1'b0, 32'h0000_1000);
        idle_steps(1);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_2000);
        idle_steps(6);

        // opcode held high for 10 cycles: back-to-back sequences
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 1'b0, 32'h0000_0100 + 32'(k));
        idle_steps(6);

        // reset while the latency-2 instance is in WAIT, then a normal overflow
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0800);
        idle_steps(1);
        do_reset();
        idle_steps(1);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0900);
        idle_steps(6);

        // randomized traffic
        mem_tbl[0] = 8'($urandom); mem_tbl[1] = 8'($urandom); mem_tbl[2] = 8'($urandom);
        for (int k = 0; k < 400; k++)
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, $urandom);
        idle_steps(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
